// File: rtl/dcache_vb_pkg.sv
// Shared types and helpers for the D-cache victim writeback buffer.
//   - cap_state_e : capture FSM states (C_IDLE, C_FILL)
//   - drn_state_e : drain FSM states (D_IDLE, D_WRITE, D_GAP)
//   - OFFSET_BITS : word-offset width for the default 8-word line
//   - line_base() : clears the word-offset bits of a word address
// Optional feature macro used by the buffer: VICTIM_FWD_EN.
package dcache_vb_pkg;

  localparam int VB_LINE_WORDS = 8;
  localparam int OFFSET_BITS   = $clog2(VB_LINE_WORDS);

  typedef enum logic {
    C_IDLE = 1'b0,
    C_FILL = 1'b1
  } cap_state_e;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_WRITE = 2'd1,
    D_GAP   = 2'd2
  } drn_state_e;

  // Word address of word 0 of the line containing addr.
  function automatic logic [18:0] line_base(input logic [18:0] addr, input int offset_bits);
    logic [18:0] mask;
    mask = (19'd1 << offset_bits) - 19'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/victim_line_store.sv
// Line data storage for the victim buffer: DEPTH slots of LINE_WORDS x 16-bit
// words. One synchronous write port (capture), one combinational read port for
// the drain path and, when VICTIM_FWD_EN is defined, a second combinational
// read port for miss-lookup forwarding.
// Ports:
//   clk                                  clock
//   we_i, wr_slot_i, wr_off_i, wr_data_i write port
//   dr_slot_i, dr_off_i -> dr_data_o     drain read port
//   lk_slot_i, lk_off_i -> lk_data_o     lookup read port (VICTIM_FWD_EN only)
module victim_line_store #(
  parameter int LINE_WORDS = 8,
  parameter int DEPTH      = 2,
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] wr_slot_i,
  input  logic [OFF_W-1:0] wr_off_i,
  input  logic [15:0]      wr_data_i,
  input  logic [PTR_W-1:0] dr_slot_i,
  input  logic [OFF_W-1:0] dr_off_i,
  output logic [15:0]      dr_data_o
`ifdef VICTIM_FWD_EN
  ,
  input  logic [PTR_W-1:0] lk_slot_i,
  input  logic [OFF_W-1:0] lk_off_i,
  output logic [15:0]      lk_data_o
`endif
);

  // Contents are qualified by the slot valid bits in the parent, so no reset.
  logic [15:0] mem_q [DEPTH][LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_slot_i][wr_off_i] <= wr_data_i;
  end

  assign dr_data_o = mem_q[dr_slot_i][dr_off_i];

`ifdef VICTIM_FWD_EN
  assign lk_data_o = mem_q[lk_slot_i][lk_off_i];
`endif

endmodule

// File: rtl/dcache_victim_buffer.sv
// Multi-line victim writeback buffer between the D-cache eviction path and the
// VWB (write-only) port of the memory arbiter. Dirty lines are captured word by
// word into a FIFO of line slots and drained as word writes over VWB.
// Optional feature macro: VICTIM_FWD_EN (forward buffered words to lookups).
// Ports:
//   clk, reset                      clock, async active-high reset
//   ev_valid/ev_first/ev_addr/ev_data/ev_ready   eviction capture stream
//   vwb_addr/vwb_data_out/vwb_access/vwb_ack/vwb_wr_en/vwb_bytesel  drain port
//   empty, full                     occupancy status
//   lookup_addr -> lookup_hit/lookup_data        miss hazard check
// Handshakes: an eviction word transfers on a clock edge where ev_valid and
// ev_ready are both high (in C_IDLE only a word with ev_first starts a line).
// A drain word transfers on an edge where vwb_access and vwb_ack are both high;
// vwb_addr/vwb_data_out are held stable while vwb_access waits for vwb_ack.
module dcache_victim_buffer
  import dcache_vb_pkg::*;
#(
  parameter int LINE_WORDS = VB_LINE_WORDS,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ev_valid,
  input  logic        ev_first,
  input  logic [18:0] ev_addr,
  input  logic [15:0] ev_data,
  output logic        ev_ready,
  output logic [18:0] vwb_addr,
  output logic [15:0] vwb_data_out,
  output logic        vwb_access,
  input  logic        vwb_ack,
  output logic        vwb_wr_en,
  output logic [1:0]  vwb_bytesel,
  output logic        empty,
  output logic        full,
  input  logic [18:0] lookup_addr,
  output logic        lookup_hit,
  output logic [15:0] lookup_data
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  cap_state_e       cap_state_q, cap_state_d;
  drn_state_e       drn_state_q, drn_state_d;
  logic [PTR_W-1:0] tail_q, tail_d, head_q, head_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OFF_W-1:0] cap_off_q, cap_off_d, drn_off_q, drn_off_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [18:0]      base_q [DEPTH];

  logic             wr_en, base_we, commit, drain_done;
  logic [OFF_W-1:0] wr_off;
  logic [15:0]      drn_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // count covers committed slots including the one being drained; a slot
  // still being captured is not counted.
  assign ev_ready = (cap_state_q == C_FILL) || (count_q < DEPTH_C);
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0) && (cap_state_q == C_IDLE);

  // Capture FSM: the line always fills the tail slot.
  always_comb begin
    cap_state_d = cap_state_q;
    cap_off_d   = cap_off_q;
    wr_en       = 1'b0;
    wr_off      = cap_off_q;
    base_we     = 1'b0;
    commit      = 1'b0;
    case (cap_state_q)
      C_IDLE: begin
        if (ev_valid && ev_first && ev_ready) begin
          wr_en       = 1'b1;
          wr_off      = '0;
          base_we     = 1'b1;
          cap_off_d   = OFF_W'(1);
          cap_state_d = C_FILL;
        end
      end
      C_FILL: begin
        if (ev_valid) begin
          wr_en = 1'b1;
          if (ev_first) begin
            // Abandon the partial line; restart in the same slot.
            wr_off    = '0;
            base_we   = 1'b1;
            cap_off_d = OFF_W'(1);
          end else begin
            cap_off_d = cap_off_q + OFF_W'(1);
            if (cap_off_q == LAST_OFF) begin
              commit      = 1'b1;
              cap_state_d = C_IDLE;
            end
          end
        end
      end
      default: cap_state_d = C_IDLE;
    endcase
  end

  // Drain FSM. valid_q is registered, so a line committed on an edge is first
  // seen here in the following cycle and never drains while capturing.
  always_comb begin
    drn_state_d = drn_state_q;
    drn_off_d   = drn_off_q;
    drain_done  = 1'b0;
    case (drn_state_q)
      D_IDLE, D_GAP: begin
        drn_off_d   = '0;
        drn_state_d = valid_q[head_q] ? D_WRITE : D_IDLE;
      end
      D_WRITE: begin
        if (vwb_ack) begin
          drn_off_d = drn_off_q + OFF_W'(1);
          if (drn_off_q == LAST_OFF) begin
            drain_done  = 1'b1;
            drn_state_d = D_GAP;
          end
        end
      end
      default: drn_state_d = D_IDLE;
    endcase
  end

  always_comb begin
    tail_d  = commit ? ptr_inc(tail_q) : tail_q;
    head_d  = drain_done ? ptr_inc(head_q) : head_q;
    valid_d = valid_q;
    if (drain_done) valid_d[head_q] = 1'b0;
    if (commit)     valid_d[tail_q] = 1'b1;
    count_d = count_q;
    if (commit && !drain_done)      count_d = count_q + CNT_W'(1);
    else if (!commit && drain_done) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_state_q <= C_IDLE;
      drn_state_q <= D_IDLE;
      tail_q      <= '0;
      head_q      <= '0;
      count_q     <= '0;
      cap_off_q   <= '0;
      drn_off_q   <= '0;
      valid_q     <= '0;
    end else begin
      cap_state_q <= cap_state_d;
      drn_state_q <= drn_state_d;
      tail_q      <= tail_d;
      head_q      <= head_d;
      count_q     <= count_d;
      cap_off_q   <= cap_off_d;
      drn_off_q   <= drn_off_d;
      valid_q     <= valid_d;
    end
  end

  // Line bases are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (base_we) base_q[tail_q] <= line_base(ev_addr, OFF_W);
  end

  assign vwb_access   = (drn_state_q == D_WRITE);
  assign vwb_wr_en    = vwb_access;
  assign vwb_bytesel  = 2'b11;
  assign vwb_addr     = vwb_access ? (base_q[head_q] | {{(19-OFF_W){1'b0}}, drn_off_q}) : 19'h0;
  assign vwb_data_out = vwb_access ? drn_word : 16'h0;

`ifdef VICTIM_FWD_EN
  logic             lk_hit;
  logic [PTR_W-1:0] lk_slot;
  logic [15:0]      lk_word;

  // Scan from head (oldest) to tail so the newest matching slot wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = head_q;
    lk_hit  = 1'b0;
    lk_slot = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = PTR_W'((int'(head_q) + i) % DEPTH);
      if (valid_q[idx] && (base_q[idx] == line_base(lookup_addr, OFF_W))) begin
        lk_hit  = 1'b1;
        lk_slot = idx;
      end
    end
  end

  assign lookup_hit  = lk_hit;
  assign lookup_data = lk_hit ? lk_word : 16'h0;
`else
  logic lk_hit;

  always_comb begin
    lk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (base_q[i] == line_base(lookup_addr, OFF_W))) lk_hit = 1'b1;
    end
  end

  assign lookup_hit  = lk_hit;
  assign lookup_data = 16'h0;
`endif

  victim_line_store #(
    .LINE_WORDS(LINE_WORDS),
    .DEPTH     (DEPTH)
  ) u_store (
    .clk       (clk),
    .we_i      (wr_en),
    .wr_slot_i (tail_q),
    .wr_off_i  (wr_off),
    .wr_data_i (ev_data),
    .dr_slot_i (head_q),
    .dr_off_i  (drn_off_q),
    .dr_data_o (drn_word)
`ifdef VICTIM_FWD_EN
    ,
    .lk_slot_i (lk_slot),
    .lk_off_i  (lookup_addr[OFF_W-1:0]),
    .lk_data_o (lk_word)
`endif
  );

endmodule

// File: tb/tb_dcache_victim_buffer.sv
// Self-checking bench for dcache_victim_buffer (LINE_WORDS=8, DEPTH=2).
// The reference model works on whole lines: each committed line pushes its
// eight expected (address, data) writes onto exp_q plus its commit cycle onto
// commit_q; a negedge monitor pops exp_q on every acknowledged VWB write.
module tb_dcache_victim_buffer;
  localparam int LW    = 8;
  localparam int DEPTH = 2;
`ifdef VICTIM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ev_valid = 1'b0, ev_first = 1'b0;
  logic [18:0] ev_addr = '0;
  logic [15:0] ev_data = '0;
  logic        ev_ready;
  logic [18:0] vwb_addr;
  logic [15:0] vwb_data_out;
  logic        vwb_access, vwb_wr_en;
  logic        vwb_ack = 1'b0;
  logic [1:0]  vwb_bytesel;
  logic        empty, full;
  logic [18:0] lookup_addr = '0;
  logic        lookup_hit;
  logic [15:0] lookup_data;

  always #5 clk = ~clk;

  dcache_victim_buffer #(.LINE_WORDS(LW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .ev_valid(ev_valid), .ev_first(ev_first), .ev_addr(ev_addr), .ev_data(ev_data),
    .ev_ready(ev_ready),
    .vwb_addr(vwb_addr), .vwb_data_out(vwb_data_out), .vwb_access(vwb_access),
    .vwb_ack(vwb_ack), .vwb_wr_en(vwb_wr_en), .vwb_bytesel(vwb_bytesel),
    .empty(empty), .full(full),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0, n_fail = 0, n_writes = 0;
  int          cyc = 0;
  logic [34:0] exp_q[$];
  int          commit_q[$];
  int          model_count = 0, words_in_line = 0, gap_state = 0;
  bit          expect_next = 1'b0;
  bit          ack_en = 1'b0;
  int          ack_lat = 2, ack_wait = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  // Ack responder: acks ack_lat cycles after a pending access, for one cycle.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ack_en) begin
        if (vwb_ack) begin
          vwb_ack  = 1'b0;
          ack_wait = 0;
        end else if (vwb_access) begin
          if (ack_wait >= ack_lat) vwb_ack = 1'b1;
          else ack_wait++;
        end else begin
          ack_wait = 0;
        end
      end
    end
  end

  // Drain monitor.
  always @(negedge clk) begin : mon
    logic [34:0] e;
    if (!reset) begin
      n_checks++;
      if (vwb_wr_en !== vwb_access || vwb_bytesel !== 2'b11) begin
        n_fail++;
        $display("FAIL port_const: wr_en=%b access=%b bytesel=%b, required wr_en=access bytesel=11",
                 vwb_wr_en, vwb_access, vwb_bytesel);
      end
      if (gap_state == 2) begin
        n_checks++;
        if (vwb_access !== expect_next) begin
          n_fail++;
          $display("FAIL gap_resume: access=%b required %b", vwb_access, expect_next);
        end
        gap_state = 0;
      end else if (gap_state == 1) begin
        n_checks++;
        if (vwb_access !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_low: access=%b required 0", vwb_access);
        end
        expect_next = (commit_q.size() > 0) && (commit_q[0] <= cyc);
        gap_state = 2;
      end
      if (vwb_access) begin
        n_checks++;
        if (commit_q.size() == 0 || commit_q[0] >= cyc) begin
          n_fail++;
          $display("FAIL drain_early: access=1 at cycle %0d, required a line committed before it", cyc);
        end
        if (vwb_ack) begin
          n_writes++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: addr=%h data=%h, required no write", vwb_addr, vwb_data_out);
          end else begin
            e = exp_q.pop_front();
            if ({vwb_addr, vwb_data_out} !== e) begin
              n_fail++;
              $display("FAIL write_data: addr=%h data=%h, required addr=%h data=%h",
                       vwb_addr, vwb_data_out, e[34:16], e[15:0]);
            end
          end
          words_in_line++;
          if (words_in_line == LW) begin
            words_in_line = 0;
            model_count--;
            if (commit_q.size() > 0) void'(commit_q.pop_front());
            gap_state = 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    commit_q.delete();
    model_count   = 0;
    words_in_line = 0;
    gap_state     = 0;
  endtask

  // Drives words start..start+n-1 of a line (data = seed+i). Reaching the last
  // word commits the line in the model.
  task automatic drive_words(input logic [18:0] addr, input logic [15:0] seed,
                             input int start, input int n, input bit bubbles);
    logic [18:0] lb;
    int t;
    lb = addr & ~19'(LW - 1);
    for (int i = start; i < start + n; i++) begin
      if (bubbles) repeat ($urandom_range(0, 1)) tick();
      if (i == 0) begin
        t = 0;
        while (!ev_ready && t < 2000) begin tick(); t++; end
        n_checks++;
        if (ev_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL ready_timeout: ev_ready=%b required 1", ev_ready);
        end
      end
      ev_valid = 1'b1;
      ev_first = (i == 0);
      ev_addr  = (i == 0) ? addr : 19'($urandom);
      ev_data  = seed + 16'(i);
      if (i == LW - 1) begin
        for (int j = 0; j < LW; j++) exp_q.push_back({lb + 19'(j), seed + 16'(j)});
        commit_q.push_back(cyc + 1);
        model_count++;
      end
      tick();
      ev_valid = 1'b0;
      ev_first = 1'b0;
    end
  endtask

  task automatic wait_drained(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || model_count != 0 || gap_state != 0) && t < 3000) begin
      tick(); t++;
    end
    tick();
    n_checks++;
    if (exp_q.size() != 0 || model_count != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
    end
    n_checks++;
    if ({empty, full, ev_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL %s_idle_flags: empty/full/ready=%b%b%b required 101", name, empty, full, ev_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; ack_en = 1'b0; vwb_ack = 1'b0;
    ev_valid = 1'b0; ev_first = 1'b0; lookup_addr = 19'h01230;
    repeat (3) tick();
    n_checks++;
    if ({vwb_access, vwb_addr, vwb_data_out, ev_ready, empty, full, lookup_hit, lookup_data}
        !== {1'b0, 19'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_values: access=%b addr=%h data=%h ready=%b empty=%b full=%b hit=%b ldata=%h, required 0 0 0 1 1 0 0 0",
               vwb_access, vwb_addr, vwb_data_out, ev_ready, empty, full, lookup_hit, lookup_data);
    end
    clear_model();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_line();
    int w0;
    w0 = n_writes;
    ack_lat = 2; ack_en = 1'b1;
    drive_words(19'h01230, 16'hA000, 0, LW, 1'b0);
    wait_drained("basic");
    n_checks++;
    if (n_writes - w0 !== LW) begin
      n_fail++;
      $display("FAIL basic_count: writes=%0d required %0d", n_writes - w0, LW);
    end
  endtask

  task automatic test_full();
    bit prev_ready;
    int t;
    ack_en = 1'b0; vwb_ack = 1'b0;
    drive_words(19'($urandom), 16'($urandom), 0, LW, 1'b1);
    drive_words(19'($urandom), 16'($urandom), 0, LW, 1'b1);
    n_checks++;
    if ({full, ev_ready, empty} !== 3'b100) begin
      n_fail++;
      $display("FAIL full_flags: full/ready/empty=%b%b%b required 100", full, ev_ready, empty);
    end
    // Third line start while full must be refused.
    ev_valid = 1'b1; ev_first = 1'b1; ev_addr = 19'h77770; ev_data = 16'h5555;
    repeat (3) tick();
    n_checks++;
    if (ev_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_refuse: ev_ready=%b required 0", ev_ready);
    end
    ev_valid = 1'b0; ev_first = 1'b0;
    ack_lat = $urandom_range(0, 2); ack_en = 1'b1;
    prev_ready = ev_ready;
    t = 0;
    while (model_count == 2 && t < 500) begin
      prev_ready = ev_ready;
      tick(); t++;
    end
    n_checks++;
    if ({prev_ready, ev_ready, full} !== 3'b010) begin
      n_fail++;
      $display("FAIL full_release: ready_at_last_ack=%b ready_after=%b full=%b required 0 1 0",
               prev_ready, ev_ready, full);
    end
    wait_drained("full");
  endtask

  task automatic test_abandon();
    int w0;
    w0 = n_writes;
    ack_lat = $urandom_range(0, 3); ack_en = 1'b1;
    // Stray non-first words in idle are dropped.
    ev_valid = 1'b1; ev_first = 1'b0; ev_addr = 19'h00300; ev_data = 16'hDEAD;
    repeat (2) tick();
    ev_valid = 1'b0;
    drive_words(19'h00100, 16'($urandom), 0, 3, 1'b0);
    drive_words(19'h00200, 16'($urandom), 0, LW, 1'b1);
    wait_drained("abandon");
    n_checks++;
    if (n_writes - w0 !== LW) begin
      n_fail++;
      $display("FAIL abandon_count: writes=%0d required %0d", n_writes - w0, LW);
    end
  endtask

  task automatic test_lookup();
    logic [2:0] off;
    ack_en = 1'b0; vwb_ack = 1'b0;
    drive_words(19'h04560, 16'hBEEA, 0, LW, 1'b0);
    lookup_addr = 19'h04565; #1;
    n_checks++;
    if ({lookup_hit, lookup_data} !== {1'b1, FWD ? 16'hBEEF : 16'h0}) begin
      n_fail++;
      $display("FAIL lookup_hit5: hit=%b data=%h required 1 %h", lookup_hit, lookup_data, FWD ? 16'hBEEF : 16'h0);
    end
    lookup_addr = 19'h04568; #1;
    n_checks++;
    if ({lookup_hit, lookup_data} !== 17'h0) begin
      n_fail++;
      $display("FAIL lookup_miss: hit=%b data=%h required 0 0000", lookup_hit, lookup_data);
    end
    for (int k = 0; k < 4; k++) begin
      off = 3'($urandom_range(0, 7));
      lookup_addr = 19'h04560 | 19'(off); #1;
      n_checks++;
      if ({lookup_hit, lookup_data} !== {1'b1, FWD ? 16'hBEEA + 16'(off) : 16'h0}) begin
        n_fail++;
        $display("FAIL lookup_rand: off=%0d hit=%b data=%h required 1 %h", off, lookup_hit, lookup_data,
                 FWD ? 16'hBEEA + 16'(off) : 16'h0);
      end
    end
    // Second copy of the same line: the newer slot supplies the data.
    drive_words(19'h04567, 16'hC000, 0, LW, 1'b0);
    lookup_addr = 19'h04565; #1;
    n_checks++;
    if ({lookup_hit, lookup_data} !== {1'b1, FWD ? 16'hC005 : 16'h0}) begin
      n_fail++;
      $display("FAIL lookup_newest: hit=%b data=%h required 1 %h", lookup_hit, lookup_data, FWD ? 16'hC005 : 16'h0);
    end
    ack_lat = $urandom_range(0, 3); ack_en = 1'b1;
    wait_drained("lookup");
    n_checks++;
    if (lookup_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL lookup_after_drain: hit=%b required 0", lookup_hit);
    end
    lookup_addr = 19'h0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] seed2;
    ack_en = 1'b0; vwb_ack = 1'b0;
    seed2 = 16'($urandom);
    drive_words(19'h11110, 16'($urandom), 0, LW, 1'b0);
    drive_words(19'h22220, seed2, 0, LW - 1, 1'b0);
    for (int w = 0; w < LW - 1; w++) begin
      vwb_ack = 1'b1; tick();
      vwb_ack = 1'b0; tick();
    end
    // Last ack of line 1 coincides with the committing word of line 2.
    vwb_ack  = 1'b1;
    ev_valid = 1'b1; ev_first = 1'b0; ev_addr = 19'($urandom); ev_data = seed2 + 16'(LW - 1);
    for (int j = 0; j < LW; j++) exp_q.push_back({19'h22220 + 19'(j), seed2 + 16'(j)});
    commit_q.push_back(cyc + 1);
    model_count++;
    tick();
    vwb_ack = 1'b0; ev_valid = 1'b0;
    n_checks++;
    if ({full, empty, ev_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL simul_count: full/empty/ready=%b%b%b required 001 (one line held)", full, empty, ev_ready);
    end
    ack_lat = $urandom_range(0, 3); ack_en = 1'b1;
    wait_drained("simul");
  endtask

  task automatic test_random_stream();
    ack_en = 1'b1;
    for (int n = 0; n < 6; n++) begin
      ack_lat = $urandom_range(0, 3);
      drive_words(19'($urandom), 16'($urandom), 0, LW, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drained("random");
  endtask

  task automatic test_reset_mid_drain();
    int t, w0;
    ack_lat = 1; ack_en = 1'b1;
    drive_words(19'h3ABC8, 16'($urandom), 0, LW, 1'b0);
    t = 0;
    while (!(words_in_line == 3 && vwb_access) && t < 500) begin tick(); t++; end
    n_checks++;
    if (!(words_in_line == 3 && vwb_access === 1'b1)) begin
      n_fail++;
      $display("FAIL rst_reach_word3: words=%0d access=%b required 3 1", words_in_line, vwb_access);
    end
    reset = 1'b1; #1;
    n_checks++;
    if ({vwb_access, vwb_addr} !== 20'h0) begin
      n_fail++;
      $display("FAIL rst_access_drop: access=%b addr=%h required 0 00000", vwb_access, vwb_addr);
    end
    ack_en = 1'b0; vwb_ack = 1'b0;
    clear_model();
    repeat (2) tick();
    reset = 1'b0;
    w0 = n_writes;
    ack_en = 1'b1;
    repeat (30) tick();
    n_checks++;
    if (n_writes !== w0 || {empty, vwb_access} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_after: writes=%0d empty=%b access=%b required 0 1 0", n_writes - w0, empty, vwb_access);
    end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_full();
    test_abandon();
    test_lookup();
    test_back_to_back();
    test_random_stream();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
